kernel_mem_loader: RTL and testbench
====================================

Name: kernel_mem_loader

Overview:
- Write-side controller for the kernel memory block (two 8-complex halves selected by `select`, 9-bit address, depth 512).
- Accepts a stream of 16-complex cachelines over a valid/ready handshake.
- Writes each line to one kernel address in two beats: low half with select=0, then high half with select=1.
- Sits between the host/DMA cacheline stream and the kernel memory write port. Counts lines and reports completion.

Parameters:
- CPLX_WIDTH, 32, width of each real and imaginary part
- ADDR_WIDTH, 9, kernel memory address width (depth 2**ADDR_WIDTH)
- LINE_ELEMS, 16, complex elements per cacheline; half = LINE_ELEMS/2

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- base_addr  input  ADDR_WIDTH  first kernel address; latched on start
- num_lines  input  ADDR_WIDTH+1  number of lines to load, 0..512; latched on start
- line_valid  input  1  cacheline present
- line_ready  output  1  loader accepts line this cycle
- line_data  input  LINE_ELEMS*2*CPLX_WIDTH  element k at [64k+63:64k]; real in upper 32 bits, imag in lower 32 bits
- mem_we  output  1  kernel memory write enable
- mem_select  output  1  0 = low half (elements 0..7), 1 = high half (elements 8..15)
- mem_write_address  output  ADDR_WIDTH  kernel write address
- mem_in  output  (LINE_ELEMS/2)*2*CPLX_WIDTH  element m at [64m+63:64m]; maps to kernel in[m/4][m%4]
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at end of job

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high.
  - On reset, all outputs go to 0 and the state goes to IDLE.
  - Reset mid-job abandons the job immediately. No further writes occur; a partially written line stays as is.
- States: IDLE, WAIT, WR_LO, WR_HI, DONE.
- IDLE:
  - On start with num_lines>0: latch addr=base_addr and remaining=num_lines, go to WAIT.
  - On start with num_lines==0: go to DONE (no writes).
- WAIT:
  - line_ready=1.
  - On line_valid&&line_ready: register line_data into the line buffer, go to WR_LO.
- WR_LO (one cycle): mem_we=1, mem_select=0, mem_write_address=addr, mem_in=buffer elements 0..7. Go to WR_HI.
- WR_HI (one cycle):
  - Outputs: mem_we=1, mem_select=1, same address, mem_in=buffer elements 8..15.
  - Decrement remaining; addr = addr+1 mod 2**ADDR_WIDTH (wraps 511→0).
  - If remaining (before decrement) > 1: line_ready=1. An accepted line goes to WR_LO; otherwise go to WAIT.
  - If remaining == 1: line_ready=0, go to DONE.
- DONE (one cycle): done=1, busy=1. Next state is IDLE.
- Output timing:
  - mem_* outputs are registered and driven during the state's cycle.
  - mem_we=0, mem_select=0, mem_write_address=0 and mem_in=0 outside WR_LO/WR_HI.
- Throughput and latency:
  - Back-to-back lines are sustained at 2 cycles/line.
  - Latency from accept to low-half write is 1 cycle.
- start is ignored while busy.
- line_valid outside WAIT/WR_HI is ignored; line_ready=0 there.
- The line buffer is loaded only on handshake. Data must not change between WR_LO and WR_HI.

Decomposition:
- Shared package, beside the existing complex typedef in common.vh:
  - KERNEL_ADDR_WIDTH=9, KERNEL_DEPTH=512, LINE_ELEMS=16
  - complex element typedef {r,i}
  - loader state enum
- No sub-module; the line buffer and half mux are inline.
- The bench instantiates the loader driving the existing kernel memory block for end-to-end readback.

Test Plan:
- Single line: reset, start with base_addr=0, num_lines=1; line k-th element = {r=k, i=100+k}.
  - Expect WR_LO at addr 0 with elements 0..7, then WR_HI with elements 8..15.
  - Expect done one cycle after WR_HI.
  - Readback of kernel address 0: out[0..1][*] = elements 0..7, out[2..3][*] = 8..15.
- Streaming: num_lines=4, line_valid held high → line_ready pulses every 2 cycles, addresses 0,0,1,1,2,2,3,3, done 9 cycles after the first accept.
- Backpressure and wrap: base_addr=510, num_lines=3, valid gaps of 3 cycles → writes to 510, 511, 0; no write while waiting; mem_we=0 in WAIT.
- num_lines=0 → done pulse on the cycle after start, mem_we never asserted, line_ready never asserted.
- Reset in WR_LO of line 2 (num_lines=4) → next cycle mem_we=0, busy=0, no done pulse. A new start with base_addr=100, num_lines=1 completes normally.
- start asserted while busy (mid-job) with different base_addr → ignored; the original job's addresses and line count are unchanged.

Source files
------------

// File: rtl/kernel_mem_loader_pkg.sv
// kernel_mem_loader_pkg: shared kernel memory geometry, complex element type and loader states
package kernel_mem_loader_pkg;
  localparam int CPLX_WIDTH = 32;
  localparam int KERNEL_ADDR_WIDTH = 9;
  localparam int KERNEL_DEPTH = 2 ** KERNEL_ADDR_WIDTH;
  localparam int LINE_ELEMS = 16;
  localparam int HALF_ELEMS = LINE_ELEMS / 2;
  typedef struct packed {
    logic [CPLX_WIDTH-1:0] r;
    logic [CPLX_WIDTH-1:0] i;
  } cplx_t;
  typedef enum logic [2:0] {IDLE, WAIT, WR_LO, WR_HI, DONE} state_t;
endpackage

// File: rtl/kernel_mem_loader_if.sv
// kernel_mem_loader_if: cacheline stream in and kernel memory write port out
interface kernel_mem_loader_if #(
  parameter int CPLX_WIDTH = kernel_mem_loader_pkg::CPLX_WIDTH,
  parameter int ADDR_WIDTH = kernel_mem_loader_pkg::KERNEL_ADDR_WIDTH,
  parameter int LINE_ELEMS = kernel_mem_loader_pkg::LINE_ELEMS
);
  localparam int LINE_W = LINE_ELEMS * 2 * CPLX_WIDTH;
  localparam int HALF_W = LINE_W / 2;
  logic line_valid;
  logic line_ready;
  logic [LINE_W-1:0] line_data;
  logic mem_we;
  logic mem_select;
  logic [ADDR_WIDTH-1:0] mem_write_address;
  logic [HALF_W-1:0] mem_in;
  modport master (
    output line_valid, line_data,
    input line_ready, mem_we, mem_select, mem_write_address, mem_in
  );
  modport slave (
    input line_valid, line_data,
    output line_ready, mem_we, mem_select, mem_write_address, mem_in
  );
endinterface

// File: rtl/kernel_mem_loader.sv
// kernel_mem_loader: writes a stream of 16-complex cachelines into kernel memory as two half-line beats
module kernel_mem_loader
  import kernel_mem_loader_pkg::*;
#(
  parameter int CPLX_WIDTH = kernel_mem_loader_pkg::CPLX_WIDTH,
  parameter int ADDR_WIDTH = kernel_mem_loader_pkg::KERNEL_ADDR_WIDTH,
  parameter int LINE_ELEMS = kernel_mem_loader_pkg::LINE_ELEMS
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0] num_lines,
  output logic busy,
  output logic done,
  kernel_mem_loader_if.slave bus
);
  localparam int LINE_W = LINE_ELEMS * 2 * CPLX_WIDTH;
  localparam int HALF_W = LINE_W / 2;
  localparam logic [ADDR_WIDTH:0] ONE_LINE = 1;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [ADDR_WIDTH:0] remaining;
  logic [LINE_W-1:0] line_buf, buf_n;
  logic ready, accept, writing_n;
  always_comb begin
    state_n = state;
    ready = 1'b0;
    unique case (state)
      IDLE:  state_n = !start ? IDLE : (num_lines == '0 ? DONE : WAIT);
      WAIT: begin
        ready = 1'b1;
        state_n = bus.line_valid ? WR_LO : WAIT;
      end
      WR_LO: state_n = WR_HI;
      WR_HI: begin
        ready = remaining > ONE_LINE;
        state_n = remaining == ONE_LINE ? DONE : (bus.line_valid ? WR_LO : WAIT);
      end
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign accept = ready && bus.line_valid;
  assign buf_n = accept ? bus.line_data : line_buf;
  // the address advances as the high half retires, so a back-to-back WR_LO already sees the next slot
  assign addr_n = state == IDLE ? base_addr : (state == WR_HI ? addr + ADDR_WIDTH'(1) : addr);
  assign writing_n = state_n == WR_LO || state_n == WR_HI;
  assign bus.line_ready = ready;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      remaining <= '0;
      line_buf <= '0;
      bus.mem_we <= 1'b0;
      bus.mem_select <= 1'b0;
      bus.mem_write_address <= '0;
      bus.mem_in <= '0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      line_buf <= buf_n;
      remaining <= state == IDLE ? num_lines : (state == WR_HI ? remaining - ONE_LINE : remaining);
      bus.mem_we <= writing_n;
      bus.mem_select <= state_n == WR_HI;
      bus.mem_write_address <= writing_n ? addr_n : '0;
      bus.mem_in <= state_n == WR_LO ? buf_n[HALF_W-1:0] : (state_n == WR_HI ? buf_n[LINE_W-1:HALF_W] : '0);
    end
  end
endmodule

// File: tb/tb_kernel_mem_loader.sv
// tb_kernel_mem_loader: directed and random jobs checked against a write-sequence model and kernel memory readback
module tb_kernel_mem_loader;
  import kernel_mem_loader_pkg::*;
  localparam int AW = 9;
  localparam int LW = 1024;
  localparam int HW = 512;
  localparam int DEPTH = 2 ** AW;
  typedef struct packed {
    logic [31:0] cyc_n;
    logic [AW-1:0] addr;
    logic sel;
    logic [HW-1:0] data;
  } wr_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] num_lines = '0;
  logic busy, done;
  kernel_mem_loader_if #(.CPLX_WIDTH(32), .ADDR_WIDTH(AW), .LINE_ELEMS(16)) bus();
  kernel_mem_loader #(.CPLX_WIDTH(32), .ADDR_WIDTH(AW), .LINE_ELEMS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_lines(num_lines),
    .busy(busy), .done(done), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int done_cnt = 0;
  bit mon_en = 1'b0;
  wr_t expq[$];
  wr_t mon_w;
  logic [HW-1:0] kmem [DEPTH][2];
  logic [HW-1:0] ref_mem [DEPTH][2];
  bit ref_v [DEPTH][2];
  task automatic chk(input string tag, input logic [599:0] obs, input logic [599:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // behavioural kernel memory: two 8-complex halves per address
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_we === 1'b1) kmem[bus.mem_write_address][bus.mem_select] <= bus.mem_in;
  end
  always @(negedge clk) if (mon_en) begin
    if (done === 1'b1) done_cnt++;
    if (bus.mem_we === 1'b1) begin
      chk("write_expected", 600'(expq.size() > 0), 600'(1));
      if (expq.size() > 0) begin
        mon_w = expq.pop_front();
        chk("write", {cyc, bus.mem_write_address, bus.mem_select, bus.mem_in}, mon_w);
        ref_mem[mon_w.addr][mon_w.sel] = mon_w.data;
        ref_v[mon_w.addr][mon_w.sel] = 1'b1;
      end
    end else chk("idle_zero", {bus.mem_select, bus.mem_write_address, bus.mem_in}, '0);
  end
  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < 32; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction
  function automatic logic [LW-1:0] ramp_line();
    logic [LW-1:0] r;
    cplx_t c;
    for (int k = 0; k < 16; k++) begin
      c.r = 32'(k);
      c.i = 32'(100 + k);
      r[64*k +: 64] = c;
    end
    return r;
  endfunction
  task automatic send_line(input logic [LW-1:0] d, output int e);
    bus.line_valid = 1'b1;
    bus.line_data = d;
    for (int t = 0; t < 30 && bus.line_ready !== 1'b1; t++) step();
    chk("ready_timeout", 600'(bus.line_ready), 600'(1));
    step();
    e = cyc;
    bus.line_valid = 1'b0;
  endtask
  // a line accepted on edge e is written low half in cycle e, high half in cycle e+1
  task automatic push_line(input logic [AW-1:0] wa, input logic [LW-1:0] wd, input int e);
    expq.push_back('{cyc_n: e, addr: wa, sel: 1'b0, data: wd[HW-1:0]});
    expq.push_back('{cyc_n: e + 1, addr: wa, sel: 1'b1, data: wd[LW-1:HW]});
  endtask
  task automatic do_job(input logic [AW-1:0] base, input int n, input int gap_lo, input int gap_hi,
                        input bit mid_start, input bit fixed);
    int first, last, e, g;
    logic [LW-1:0] d;
    bit stream;
    stream = gap_hi == 0 && !mid_start;
    first = 0;
    last = 0;
    base_addr = base;
    num_lines = (AW+1)'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    base_addr = AW'($urandom);
    num_lines = (AW+1)'($urandom);
    chk("busy_after_start", 600'(busy), 600'(1));
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(gap_hi, gap_lo);
      repeat (g) step();
      if (g >= 2) chk("wait_state", {bus.line_ready, bus.mem_we}, 600'(2'b10));
      d = fixed ? ramp_line() : rand_line();
      send_line(d, e);
      push_line(AW'((int'(base) + i) % DEPTH), d, e);
      if (i == 0) first = e;
      if (stream) chk("stream_rate", 600'(e), 600'(first + 2 * i));
      last = e;
      if (mid_start && i == 0) begin
        start = 1'b1;
        base_addr = 9'd300;
        num_lines = 10'd1;
        step();
        start = 1'b0;
      end
    end
    for (int t = 0; t < 10 && done !== 1'b1; t++) step();
    chk("done_time", 600'(cyc), 600'(last + 2));
    if (stream) chk("done_stream", 600'(cyc), 600'(first + 2 * n));
    chk("done_pulse", {done, busy}, 600'(2'b11));
    step();
    chk("idle_after_done", {done, busy, bus.line_ready}, '0);
    chk("queue_drained", 600'(expq.size()), '0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int e, dc;
    logic [LW-1:0] d, ramp;
    bus.line_valid = 1'b0;
    bus.line_data = '0;
    repeat (3) step();
    chk("reset_state", {bus.line_ready, busy, done, bus.mem_we, bus.mem_select, bus.mem_write_address, bus.mem_in}, '0);
    reset = 1'b0;
    mon_en = 1'b1;
    step();
    ramp = ramp_line();
    do_job(9'd0, 1, 0, 0, 1'b0, 1'b1);
    chk("rb_lo", kmem[0][0], ramp[HW-1:0]);
    chk("rb_hi", kmem[0][1], ramp[LW-1:HW]);
    chk("rb_elem11", kmem[0][1][192 +: 64], {32'd11, 32'd111});
    do_job(9'd0, 4, 0, 0, 1'b0, 1'b0);
    do_job(9'd510, 3, 3, 3, 1'b0, 1'b0);
    base_addr = 9'd5;
    num_lines = '0;
    bus.line_valid = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_done", {done, busy, bus.line_ready}, 600'(3'b110));
    step();
    chk("zero_idle", {done, busy, bus.line_ready}, '0);
    bus.line_valid = 1'b0;
    base_addr = 9'd40;
    num_lines = 10'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    d = rand_line();
    send_line(d, e);
    push_line(9'd40, d, e);
    d = rand_line();
    send_line(d, e);
    push_line(9'd41, d, e);
    chk("wr_lo_line2", {bus.mem_we, bus.mem_select, bus.mem_write_address}, {1'b1, 1'b0, 9'd41});
    dc = done_cnt;
    reset = 1'b1;
    step();
    chk("reset_abandon", {bus.mem_we, busy, done, bus.line_ready}, '0);
    reset = 1'b0;
    chk("reset_left_high_half", 600'(expq.size()), 600'(1));
    expq.delete();
    repeat (3) step();
    chk("no_done_after_reset", 600'(done_cnt), 600'(dc));
    do_job(9'd100, 1, 0, 0, 1'b0, 1'b0);
    do_job(9'd20, 3, 0, 1, 1'b1, 1'b0);
    repeat (6) do_job(AW'($urandom), $urandom_range(8, 1), 0, 3, 1'b0, 1'b0);
    repeat (2) step();
    for (int a = 0; a < DEPTH; a++)
      for (int s = 0; s < 2; s++)
        if (ref_v[a][s]) chk("readback", kmem[a][s], ref_mem[a][s]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
